// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one memory bus between an I-cache and a D-cache. The arbiter adds
//   no latency: the granted request is muxed straight onto proc2mem_*, and
//   returning data is steered back to the owner of its tag in the same cycle.
//   An owner table, indexed by tag, records which cache issued each
//   outstanding load.
//
// Configuration macro:
//   MEM_ARB_ROUND_ROBIN_EN  defined   -> the IDLE grant is round-robin between
//                                        the two caches.
//                           undefined -> fixed D-cache priority.
//
// Ports:
//   clock, reset                   clock; synchronous active-high reset
//   icache_command/addr            I-cache request (BUS_STORE is ignored)
//   dcache_command/addr/data       D-cache request
//   proc2mem_command/addr/data     request driven to memory
//   mem2proc_response/data/tag     memory acceptance tag, return data and tag
//   mem2icache_response/tag/data   responses steered to the I-cache
//   mem2dcache_response/tag/data   responses steered to the D-cache
//   arb_tag_error                  pulse: a returned tag had no owner, or an
//                                  accepted load overwrote a live entry
//   arb_state                      current FSM state (0 = IDLE, 1 = HOLD)
//
// Handshake: a requester holds command/addr/data stable until it sees a
// nonzero *_response. Memory accepts a request by driving a nonzero
// mem2proc_response in the same cycle the command is on the bus. A response
// of 0 means "not yet", and the grant is then held until acceptance.

`ifndef XLEN
`define XLEN 32
`endif

module mem_bus_arbiter #(
    parameter int TAG_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        icache_command,
    input  logic [`XLEN-1:0]  icache_addr,
    input  logic [1:0]        dcache_command,
    input  logic [`XLEN-1:0]  dcache_addr,
    input  logic [63:0]       dcache_data,
    output logic [1:0]        proc2mem_command,
    output logic [`XLEN-1:0]  proc2mem_addr,
    output logic [63:0]       proc2mem_data,
    input  logic [TAG_W-1:0]  mem2proc_response,
    input  logic [63:0]       mem2proc_data,
    input  logic [TAG_W-1:0]  mem2proc_tag,
    output logic [TAG_W-1:0]  mem2icache_response,
    output logic [TAG_W-1:0]  mem2icache_tag,
    output logic [63:0]       mem2icache_data,
    output logic [TAG_W-1:0]  mem2dcache_response,
    output logic [TAG_W-1:0]  mem2dcache_tag,
    output logic [63:0]       mem2dcache_data,
    output logic              arb_tag_error,
    output logic              arb_state
);

    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;
    localparam int         NUM_TAGS  = 1 << TAG_W;

    typedef enum logic {S_IDLE = 1'b0, S_HOLD = 1'b1} state_t;

    state_t               state_q, state_d;
    logic                 grant_q, grant_d;       // 1 = I-cache, 0 = D-cache
    logic [NUM_TAGS-1:0]  owner_valid_q;
    logic [NUM_TAGS-1:0]  owner_icache_q;         // 1 = entry owned by I-cache

    logic [1:0]           icmd;
    logic                 dreq, ireq;
    logic                 sel_icache, active;
    logic [1:0]           cmd_sel;
    logic                 accepted, accept_load;
    logic                 ret_hit, ret_miss, overwrite_err;

    // The I-cache never writes, so a store from it is not a request.
    assign icmd = (icache_command == BUS_STORE) ? BUS_NONE : icache_command;
    assign dreq = (dcache_command != BUS_NONE);
    assign ireq = (icmd != BUS_NONE);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic rr_q;                                   // 1 = I-cache preferred next
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_q <= 1'b0;
        end else if (accepted) begin
            rr_q <= ~sel_icache;
        end
    end
`endif

    // Grant selection. In HOLD the registered grant is kept even when the
    // other cache requests; if the held requester drops its command the bus
    // goes quiet and the FSM falls back to IDLE.
    always_comb begin
        sel_icache = 1'b0;
        active     = 1'b0;
        if (state_q == S_HOLD) begin
            sel_icache = grant_q;
            active     = grant_q ? ireq : dreq;
        end else begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            sel_icache = (dreq && ireq) ? rr_q : ireq;
`else
            sel_icache = !dreq && ireq;
`endif
            active     = dreq || ireq;
        end
        if (reset) begin
            active = 1'b0;
        end
    end

    assign cmd_sel     = active ? (sel_icache ? icmd : dcache_command) : BUS_NONE;
    assign accepted    = active && (mem2proc_response != '0);
    assign accept_load = accepted && (cmd_sel == BUS_LOAD);

    assign proc2mem_command = cmd_sel;
    assign proc2mem_addr    = !active ? '0 : (sel_icache ? icache_addr : dcache_addr);
    assign proc2mem_data    = (active && !sel_icache) ? dcache_data : 64'd0;

    assign mem2icache_response = (active &&  sel_icache) ? mem2proc_response : '0;
    assign mem2dcache_response = (active && !sel_icache) ? mem2proc_response : '0;

    // Tag return path.
    assign ret_hit  = !reset && (mem2proc_tag != '0) &&  owner_valid_q[mem2proc_tag];
    assign ret_miss = !reset && (mem2proc_tag != '0) && !owner_valid_q[mem2proc_tag];

    // Reusing a tag that is being returned in the same cycle is legal;
    // only a live entry that survives this cycle counts as an overwrite.
    assign overwrite_err = accept_load && owner_valid_q[mem2proc_response] &&
                           !(ret_hit && (mem2proc_tag == mem2proc_response));
    assign arb_tag_error = ret_miss || overwrite_err;

    assign mem2icache_tag  = (ret_hit &&  owner_icache_q[mem2proc_tag]) ? mem2proc_tag  : '0;
    assign mem2icache_data = (ret_hit &&  owner_icache_q[mem2proc_tag]) ? mem2proc_data : 64'd0;
    assign mem2dcache_tag  = (ret_hit && !owner_icache_q[mem2proc_tag]) ? mem2proc_tag  : '0;
    assign mem2dcache_data = (ret_hit && !owner_icache_q[mem2proc_tag]) ? mem2proc_data : 64'd0;

    always_comb begin
        state_d = S_IDLE;
        grant_d = grant_q;
        if (active && (mem2proc_response == '0)) begin
            state_d = S_HOLD;
            grant_d = sel_icache;
        end
    end

    assign arb_state = (state_q == S_HOLD);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            grant_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    // Owner table: the clear comes first so that a same-cycle reuse of the
    // returning tag leaves the entry valid with its new owner.
    always_ff @(posedge clock) begin
        if (reset) begin
            owner_valid_q  <= '0;
            owner_icache_q <= '0;
        end else begin
            if (ret_hit) begin
                owner_valid_q[mem2proc_tag] <= 1'b0;
            end
            if (accept_load) begin
                owner_valid_q[mem2proc_response]  <= 1'b1;
                owner_icache_q[mem2proc_response] <= sel_icache;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
//   Directed scenarios followed by random traffic. Expected outputs come from
//   a reference model that tracks who holds the bus and which cache owns each
//   outstanding tag (an associative array keyed by tag).

`ifndef XLEN
`define XLEN 32
`endif

module tb_mem_bus_arbiter;
  localparam int TAG_W = 4;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic              clock = 1'b0;
  logic              reset;
  logic [1:0]        icache_command, dcache_command;
  logic [`XLEN-1:0]  icache_addr, dcache_addr;
  logic [63:0]       dcache_data;
  logic [1:0]        proc2mem_command;
  logic [`XLEN-1:0]  proc2mem_addr;
  logic [63:0]       proc2mem_data;
  logic [TAG_W-1:0]  mem2proc_response, mem2proc_tag;
  logic [63:0]       mem2proc_data;
  logic [TAG_W-1:0]  mem2icache_response, mem2icache_tag;
  logic [63:0]       mem2icache_data;
  logic [TAG_W-1:0]  mem2dcache_response, mem2dcache_tag;
  logic [63:0]       mem2dcache_data;
  logic              arb_tag_error;
  logic              arb_state;

  always #5 clock = ~clock;

  mem_bus_arbiter #(.TAG_W(TAG_W)) dut (
    .clock(clock), .reset(reset),
    .icache_command(icache_command), .icache_addr(icache_addr),
    .dcache_command(dcache_command), .dcache_addr(dcache_addr), .dcache_data(dcache_data),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr), .proc2mem_data(proc2mem_data),
    .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data), .mem2proc_tag(mem2proc_tag),
    .mem2icache_response(mem2icache_response), .mem2icache_tag(mem2icache_tag), .mem2icache_data(mem2icache_data),
    .mem2dcache_response(mem2dcache_response), .mem2dcache_tag(mem2dcache_tag), .mem2dcache_data(mem2dcache_data),
    .arb_tag_error(arb_tag_error), .arb_state(arb_state)
  );

  // ---------------- scoreboard counters ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // who: 0 = nobody, 1 = D-cache, 2 = I-cache
  int tbl[int];          // tag -> owning cache
  bit hold;              // bus is being held for hold_who
  int hold_who;
  int pref;              // round-robin preference

  // per-cycle results shared between eval and commit
  int m_who;
  bit m_ret_ok;
  bit m_load;

  logic [1:0]        e_cmd;
  logic [`XLEN-1:0]  e_addr;
  logic [63:0]       e_pdata, e_idata, e_ddata;
  logic [TAG_W-1:0]  e_iresp, e_dresp, e_itag, e_dtag;
  logic              e_err;

  task automatic model_eval();
    logic [1:0] ic, c;
    int who;
    int t;
    ic = (icache_command == 2'd2) ? 2'd0 : icache_command;
    if (reset) who = 0;
    else if (hold) who = hold_who;
    else if (dcache_command != 0 && ic != 0) who = RR_EN ? pref : 1;
    else if (dcache_command != 0) who = 1;
    else if (ic != 0) who = 2;
    else who = 0;
    c = (who == 1) ? dcache_command : (who == 2) ? ic : 2'd0;
    if (c == 0) who = 0;
    m_who   = who;
    e_cmd   = c;
    e_addr  = (who == 1) ? dcache_addr : (who == 2) ? icache_addr : '0;
    e_pdata = (who == 1) ? dcache_data : 64'd0;
    e_dresp = (who == 1) ? mem2proc_response : '0;
    e_iresp = (who == 2) ? mem2proc_response : '0;
    e_itag = '0; e_dtag = '0; e_idata = 64'd0; e_ddata = 64'd0;
    e_err = 1'b0;
    m_ret_ok = 1'b0;
    t = int'(mem2proc_tag);
    if (!reset && t != 0) begin
      if (tbl.exists(t)) begin
        m_ret_ok = 1'b1;
        if (tbl[t] == 1) begin e_dtag = mem2proc_tag; e_ddata = mem2proc_data; end
        else             begin e_itag = mem2proc_tag; e_idata = mem2proc_data; end
      end else begin
        e_err = 1'b1;
      end
    end
    m_load = (who != 0) && (mem2proc_response != 0) && (c == 2'd1);
    if (m_load && tbl.exists(int'(mem2proc_response)) &&
        !(m_ret_ok && mem2proc_tag == mem2proc_response))
      e_err = 1'b1;
  endtask

  task automatic model_commit();
    if (reset) begin
      tbl.delete();
      hold = 1'b0;
      pref = 1;
      return;
    end
    if (m_ret_ok) tbl.delete(int'(mem2proc_tag));
    if (m_load) tbl[int'(mem2proc_response)] = m_who;
    hold     = (m_who != 0) && (mem2proc_response == 0);
    hold_who = m_who;
    if (m_who != 0 && mem2proc_response != 0) pref = (m_who == 1) ? 2 : 1;
  endtask

  // ---------------- driver ----------------
  // Inputs are applied right after a falling edge; step settles, compares
  // against the model, advances the model and waits for the next falling edge.
  task automatic step();
    #1;
    model_eval();
    chk("p2m_cmd",   proc2mem_command,    e_cmd);
    chk("p2m_addr",  proc2mem_addr,       e_addr);
    chk("p2m_data",  proc2mem_data,       e_pdata);
    chk("i_resp",    mem2icache_response, e_iresp);
    chk("d_resp",    mem2dcache_response, e_dresp);
    chk("i_tag",     mem2icache_tag,      e_itag);
    chk("d_tag",     mem2dcache_tag,      e_dtag);
    chk("i_data",    mem2icache_data,     e_idata);
    chk("d_data",    mem2dcache_data,     e_ddata);
    chk("tag_err",   arb_tag_error,       e_err);
    chk("state",     arb_state,           hold);
    model_commit();
    @(negedge clock);
  endtask

  task automatic drive(input logic [1:0] ic, input logic [1:0] dc,
                       input logic [TAG_W-1:0] resp, input logic [TAG_W-1:0] tag,
                       input logic [63:0] mdata);
    icache_command    = ic;
    dcache_command    = dc;
    mem2proc_response = resp;
    mem2proc_tag      = tag;
    mem2proc_data     = mdata;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [TAG_W-1:0] rr_resp;
    hold = 1'b0; hold_who = 0; pref = 1;
    reset = 1'b1;
    icache_addr = 'h200; dcache_addr = 'h100; dcache_data = 64'h1111_2222_3333_4444;
    drive(2'd1, 2'd1, 4'd3, 4'd0, 64'd0);
    // reset: all outputs quiet even with requests pending
    #1;
    chk("rst_cmd",  proc2mem_command, 2'd0);
    chk("rst_resp", mem2dcache_response, 4'd0);
    step();
    drive(2'd0, 2'd0, 4'd0, 4'd0, 64'd0);
    step();
    reset = 1'b0;

    // both load, response 3 -> D-cache
    drive(2'd1, 2'd1, 4'd3, 4'd0, 64'd0);
    #1;
    chk("s1_dresp", mem2dcache_response, 4'd3);
    chk("s1_iresp", mem2icache_response, 4'd0);
    step();
    drive(2'd0, 2'd0, 4'd0, 4'd3, 64'hDEAD);
    #1;
    chk("s1_dtag",  mem2dcache_tag,  4'd3);
    chk("s1_ddata", mem2dcache_data, 64'hDEAD);
    chk("s1_itag",  mem2icache_tag,  4'd0);
    step();

    // I-cache held through two stalls while D-cache requests
    icache_addr = 'h300;
    drive(2'd1, 2'd0, 4'd0, 4'd0, 64'd0);
    step();
    for (int i = 0; i < 2; i++) begin
      drive(2'd1, 2'd1, (i == 0) ? 4'd0 : 4'd5, 4'd0, 64'd0);
      #1;
      chk("s2_addr", proc2mem_addr, 'h300);
      step();
    end
    drive(2'd0, 2'd0, 4'd0, 4'd0, 64'd0);
    #1;
    chk("s2_idle", arb_state, 1'b0);
    step();

    // continuous requests from both, responses 1..4
    icache_addr = 'h400; dcache_addr = 'h500;
    for (int i = 1; i <= 4; i++) begin
      rr_resp = TAG_W'(i);
      drive(2'd1, 2'd1, rr_resp, 4'd0, 64'd0);
      #1;
      if (RR_EN && (i % 2 == 0)) chk("s3_grant_i", mem2icache_response, rr_resp);
      else                       chk("s3_grant_d", mem2dcache_response, rr_resp);
      step();
    end

    // tag 4 returned while tag 4 reissued to a new load: no error
    drive(2'd0, 2'd1, 4'd4, 4'd4, 64'hBEEF);
    #1;
    chk("s4_err", arb_tag_error, 1'b0);
    chk("s4_tag", {mem2icache_tag, mem2dcache_tag}, RR_EN ? 8'h40 : 8'h04);
    step();

    // D-cache store accepted as 7, tag 7 returned later -> unowned
    drive(2'd0, 2'd2, 4'd7, 4'd0, 64'd0);
    step();
    drive(2'd0, 2'd0, 4'd0, 4'd7, 64'h77);
    #1;
    chk("s5_err",  arb_tag_error, 1'b1);
    chk("s5_dtag", mem2dcache_tag, 4'd0);
    step();

    // load accepted as 9, reset, then tag 9 returns -> unowned
    drive(2'd1, 2'd0, 4'd9, 4'd0, 64'd0);
    step();
    reset = 1'b1;
    drive(2'd0, 2'd0, 4'd0, 4'd0, 64'd0);
    step();
    reset = 1'b0;
    drive(2'd0, 2'd0, 4'd0, 4'd9, 64'h99);
    #1;
    chk("s6_err",  arb_tag_error, 1'b1);
    chk("s6_tags", {mem2icache_tag, mem2dcache_tag}, 8'h00);
    step();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 49) == 0);
      icache_addr = $urandom; dcache_addr = $urandom;
      dcache_data = {$urandom, $urandom};
      drive(2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)),
            ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15)),
            ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15)),
            {$urandom, $urandom});
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
